// File: rtl/oldland_fetch_pkg.sv
// rtl/oldland_fetch_pkg.sv - shared encodings for the oldland fetch stage
package oldland_fetch_pkg;

  localparam logic [31:0] NOP_ENC   = 32'h0000_0000;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_SKID   = 2'd2,
    ST_SQUASH = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/oldland_fetch_skid.sv
// rtl/oldland_fetch_skid.sv - one-entry {instr, pc_plus_4} holding buffer
module oldland_fetch_skid
  import oldland_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc_plus_4,
  output logic        full,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus_4
);

  logic        full_q, full_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus_4_q, pc_plus_4_d;

  // Flush wins so a redirect can never leak a stale word out of the buffer.
  always_comb begin
    full_d      = full_q;
    instr_d     = instr_q;
    pc_plus_4_d = pc_plus_4_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d      = 1'b1;
      instr_d     = in_instr;
      pc_plus_4_d = in_pc_plus_4;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= 1'b0;
      instr_q     <= NOP_ENC;
      pc_plus_4_q <= 32'h0;
    end else begin
      full_q      <= full_d;
      instr_q     <= instr_d;
      pc_plus_4_q <= pc_plus_4_d;
    end
  end

  assign full          = full_q;
  assign out_instr     = instr_q;
  assign out_pc_plus_4 = pc_plus_4_q;

endmodule

// File: rtl/oldland_fetch.sv
// rtl/oldland_fetch.sv - instruction fetch stage: PC, imem req/ack, decode outputs
module oldland_fetch
  import oldland_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VEC,
  parameter logic [31:0] NOP_INSTR    = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] i_addr,
  output logic        i_req,
  input  logic        i_ack,
  input  logic [31:0] i_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] pc_plus_4,
  output logic        instr_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_plus_4_q, pc_plus_4_d;
  logic         valid_q, valid_d;

  logic         ack;
  logic [31:0]  pc_inc;
  logic [31:0]  branch_addr;
  logic         skid_load, skid_unload, skid_flush, skid_full;
  logic [31:0]  skid_instr, skid_pc_plus_4;

  assign i_req       = (state_q == ST_FETCH) || (state_q == ST_SQUASH);
  assign i_addr      = pc_q;
  // An ack only counts against a live request; late acks after reset are dropped.
  assign ack         = i_ack && i_req;
  assign pc_inc      = pc_q + 32'd4;
  assign branch_addr = word_align(branch_target);

  oldland_fetch_skid u_skid (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (skid_load),
    .unload        (skid_unload),
    .flush         (skid_flush),
    .in_instr      (i_data),
    .in_pc_plus_4  (pc_inc),
    .full          (skid_full),
    .out_instr     (skid_instr),
    .out_pc_plus_4 (skid_pc_plus_4)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    instr_d     = instr_q;
    pc_plus_4_d = pc_plus_4_q;
    valid_d     = valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;

    if (branch_taken) begin
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      skid_flush = 1'b1;
      // A read still in flight must complete before the new address can be issued.
      if (i_req && !ack) begin
        target_d = branch_addr;
        state_d  = ST_SQUASH;
      end else begin
        pc_d    = branch_addr;
        state_d = ST_FETCH;
      end
    end else begin
      if (!stall) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      unique case (state_q)
        ST_IDLE: state_d = ST_FETCH;
        ST_FETCH: begin
          if (ack) begin
            pc_d = pc_inc;
            if (stall) begin
              skid_load = 1'b1;
              state_d   = ST_SKID;
            end else begin
              instr_d     = i_data;
              pc_plus_4_d = pc_inc;
              valid_d     = 1'b1;
            end
          end
        end
        ST_SKID: begin
          if (!stall) begin
            skid_unload = 1'b1;
            state_d     = ST_FETCH;
            if (skid_full) begin
              instr_d     = skid_instr;
              pc_plus_4_d = skid_pc_plus_4;
              valid_d     = 1'b1;
            end
          end
        end
        ST_SQUASH: begin
          if (ack) begin
            pc_d    = target_q;
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_VECTOR;
      target_q    <= RESET_VECTOR;
      instr_q     <= NOP_INSTR;
      pc_plus_4_q <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      instr_q     <= instr_d;
      pc_plus_4_q <= pc_plus_4_d;
      valid_q     <= valid_d;
    end
  end

  assign instr       = instr_q;
  assign pc_plus_4   = pc_plus_4_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_oldland_fetch.sv
// tb/tb_oldland_fetch.sv - directed self-checking bench for oldland_fetch
module tb_oldland_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_addr;
  logic        i_req;
  logic        i_ack = 1'b0;
  logic [31:0] i_data = 32'h0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] instr;
  logic [31:0] pc_plus_4;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;

  oldland_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_addr        (i_addr),
    .i_req         (i_req),
    .i_ack         (i_ack),
    .i_data        (i_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .pc_plus_4     (pc_plus_4),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (i_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", i_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 00000000", instr); end
    checks++; if (pc_plus_4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h want 00000000", pc_plus_4); end
    rst_n = 1'b1;
    #1;
    checks++; if (i_req !== 1'b0) begin errors++; $display("FAIL idle_req got %0b want 0", i_req); end
    tick();
    checks++; if (i_req !== 1'b1) begin errors++; $display("FAIL first_req got %0b want 1", i_req); end
    checks++; if (i_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h want 00000000", i_addr); end
  endtask

  task automatic test_streaming();
    i_ack = 1'b1; i_data = 32'h11;
    tick();
    checks++; if (instr !== 32'h11) begin errors++; $display("FAIL stream0_instr got %h want 00000011", instr); end
    checks++; if (pc_plus_4 !== 32'h4) begin errors++; $display("FAIL stream0_pc4 got %h want 00000004", pc_plus_4); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream0_valid got %0b want 1", instr_valid); end
    checks++; if (i_addr !== 32'h4) begin errors++; $display("FAIL stream0_addr got %h want 00000004", i_addr); end
    i_data = 32'h22;
    tick();
    checks++; if (instr !== 32'h22) begin errors++; $display("FAIL stream1_instr got %h want 00000022", instr); end
    checks++; if (pc_plus_4 !== 32'h8) begin errors++; $display("FAIL stream1_pc4 got %h want 00000008", pc_plus_4); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream1_valid got %0b want 1", instr_valid); end
    checks++; if (i_addr !== 32'h8) begin errors++; $display("FAIL stream1_addr got %h want 00000008", i_addr); end
  endtask

  task automatic test_stall_ack();
    stall = 1'b1; i_ack = 1'b1; i_data = 32'h33;
    tick();
    i_ack = 1'b0;
    checks++; if (instr !== 32'h22) begin errors++; $display("FAIL stall_hold_instr got %h want 00000022", instr); end
    checks++; if (pc_plus_4 !== 32'h8) begin errors++; $display("FAIL stall_hold_pc4 got %h want 00000008", pc_plus_4); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid got %0b want 1", instr_valid); end
    checks++; if (i_req !== 1'b0) begin errors++; $display("FAIL skid_req got %0b want 0", i_req); end
    tick();
    checks++; if (instr !== 32'h22) begin errors++; $display("FAIL stall_hold2_instr got %h want 00000022", instr); end
    checks++; if (i_req !== 1'b0) begin errors++; $display("FAIL skid_req2 got %0b want 0", i_req); end
    stall = 1'b0;
    tick();
    checks++; if (instr !== 32'h33) begin errors++; $display("FAIL unskid_instr got %h want 00000033", instr); end
    checks++; if (pc_plus_4 !== 32'hC) begin errors++; $display("FAIL unskid_pc4 got %h want 0000000c", pc_plus_4); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL unskid_valid got %0b want 1", instr_valid); end
    checks++; if (i_req !== 1'b1 || i_addr !== 32'hC) begin errors++; $display("FAIL unskid_addr got req=%0b addr=%h want req=1 addr=0000000c", i_req, i_addr); end
  endtask

  task automatic test_squash();
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL squash_bubble got valid=%0b instr=%h want valid=0 instr=00000000", instr_valid, instr); end
    checks++; if (i_req !== 1'b1 || i_addr !== 32'hC) begin errors++; $display("FAIL squash_hold_addr got req=%0b addr=%h want req=1 addr=0000000c", i_req, i_addr); end
    tick();
    tick();
    checks++; if (i_addr !== 32'hC) begin errors++; $display("FAIL squash_wait_addr got %h want 0000000c", i_addr); end
    i_ack = 1'b1; i_data = 32'hDEAD;
    tick();
    i_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr === 32'hDEAD) begin errors++; $display("FAIL squash_drop got valid=%0b instr=%h want valid=0 instr=00000000", instr_valid, instr); end
    checks++; if (i_addr !== 32'h100) begin errors++; $display("FAIL squash_redirect got %h want 00000100", i_addr); end
  endtask

  task automatic test_squash_retarget();
    i_ack = 1'b1; i_data = 32'h55;
    tick();
    i_ack = 1'b0;
    checks++; if (instr !== 32'h55 || pc_plus_4 !== 32'h104) begin errors++; $display("FAIL retarget_pre got instr=%h pc4=%h want 00000055/00000104", instr, pc_plus_4); end
    branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    branch_target = 32'h340;
    tick();
    branch_taken = 1'b0;
    checks++; if (i_req !== 1'b1 || i_addr !== 32'h104) begin errors++; $display("FAIL retarget_hold got req=%0b addr=%h want req=1 addr=00000104", i_req, i_addr); end
    i_ack = 1'b1; i_data = 32'h66;
    tick();
    i_ack = 1'b0;
    checks++; if (i_addr !== 32'h340) begin errors++; $display("FAIL retarget_addr got %h want 00000340", i_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL retarget_valid got %0b want 0", instr_valid); end
  endtask

  task automatic test_branch_ack_stall();
    i_ack = 1'b1; i_data = 32'h77;
    tick();
    checks++; if (instr !== 32'h77 || pc_plus_4 !== 32'h344 || instr_valid !== 1'b1) begin errors++; $display("FAIL bas_pre got instr=%h pc4=%h valid=%0b want 00000077/00000344/1", instr, pc_plus_4, instr_valid); end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h203; i_data = 32'hBEEF;
    tick();
    stall = 1'b0; branch_taken = 1'b0; i_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL bas_bubble got valid=%0b instr=%h want valid=0 instr=00000000", instr_valid, instr); end
    checks++; if (i_req !== 1'b1 || i_addr !== 32'h200) begin errors++; $display("FAIL bas_addr got req=%0b addr=%h want req=1 addr=00000200", i_req, i_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bas_drop got %0b want 0", instr_valid); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; i_ack = 1'b1; i_data = 32'h0;
    tick();
    branch_taken = 1'b0;
    checks++; if (i_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h want fffffffc", i_addr); end
    i_data = 32'h88;
    tick();
    i_ack = 1'b0;
    checks++; if (instr !== 32'h88 || pc_plus_4 !== 32'h0 || instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_out got instr=%h pc4=%h valid=%0b want 00000088/00000000/1", instr, pc_plus_4, instr_valid); end
    checks++; if (i_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 00000000", i_addr); end
  endtask

  task automatic test_midop_reset();
    checks++; if (i_req !== 1'b1) begin errors++; $display("FAIL midrst_pre_req got %0b want 1", i_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (i_req !== 1'b0) begin errors++; $display("FAIL midrst_req got %0b want 0", i_req); end
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL midrst_out got valid=%0b instr=%h want 0/00000000", instr_valid, instr); end
    i_ack = 1'b1; i_data = 32'h99;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (i_req !== 1'b0) begin errors++; $display("FAIL midrst_idle got %0b want 0", i_req); end
    tick();
    i_ack = 1'b0;
    checks++; if (i_req !== 1'b1 || i_addr !== 32'h0) begin errors++; $display("FAIL midrst_restart got req=%0b addr=%h want 1/00000000", i_req, i_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_late_ack got %0b want 0", instr_valid); end
    i_ack = 1'b1; i_data = 32'hAA;
    tick();
    i_ack = 1'b0;
    checks++; if (instr !== 32'hAA || pc_plus_4 !== 32'h4 || instr_valid !== 1'b1) begin errors++; $display("FAIL midrst_first got instr=%h pc4=%h valid=%0b want 000000aa/00000004/1", instr, pc_plus_4, instr_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_ack();
    test_squash();
    test_squash_retarget();
    test_branch_ack_stall();
    test_wrap();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
